// File: rtl/aes_pkg.sv
// Shared AES types, engine state encoding and GF(2^8) helpers.
// Used by the SubBytes engine and by the key-expansion S-box lanes.
package aes_pkg;

   localparam int AES_BLOCK_BYTES = 16;

   typedef logic [7:0] byte_t;
   typedef byte_t [AES_BLOCK_BYTES-1:0] state_t;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SUB   = 2'd1,
      ST_DRAIN = 2'd2
   } eng_state_e;

   // Multiplication modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
   function automatic byte_t gf_mul(byte_t a, byte_t b);
      byte_t p;
      byte_t aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
   function automatic byte_t gf_inv(byte_t a);
      byte_t r;
      byte_t p;
      r = 8'h01;
      p = a;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) r = gf_mul(r, p);
         p = gf_mul(p, p);
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_sub_bytes_engine_if.sv
// Byte-stream handshake bundle between the SubBytes engine and its neighbours.
// The master drives input bytes and consumes output bytes; the engine is the slave.
interface aes_sub_bytes_engine_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_byte;
   logic       inv;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_byte;

   modport master (
      output in_valid, in_byte, inv, out_ready,
      input  in_ready, out_valid, out_byte
   );

   modport slave (
      input  in_valid, in_byte, inv, out_ready,
      output in_ready, out_valid, out_byte
   );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box computed as GF inverse plus affine map.
// Both directions share one GF inverter; the inverse affine exists only when INV_EN=1.
module aes_sbox
   import aes_pkg::*;
#(
   parameter bit INV_EN = 1'b1
) (
   input  byte_t i_in,
   input  logic  i_inv,
   output byte_t o_out
);

   byte_t w_gf_in;
   byte_t w_gf_out;
   byte_t w_fwd;

   assign w_gf_out = gf_inv(w_gf_in);
   assign w_fwd    = w_gf_out
                   ^ {w_gf_out[6:0], w_gf_out[7]}
                   ^ {w_gf_out[5:0], w_gf_out[7:6]}
                   ^ {w_gf_out[4:0], w_gf_out[7:5]}
                   ^ {w_gf_out[3:0], w_gf_out[7:4]}
                   ^ 8'h63;

   generate
      if (INV_EN) begin : g_inv
         byte_t w_inv_aff;
         assign w_inv_aff = {i_in[6:0], i_in[7]}
                          ^ {i_in[4:0], i_in[7:5]}
                          ^ {i_in[1:0], i_in[7:2]}
                          ^ 8'h05;
         assign w_gf_in = i_inv ? w_inv_aff : i_in;
         assign o_out   = i_inv ? w_gf_out : w_fwd;
      end else begin : g_fwd
         assign w_gf_in = i_in;
         assign o_out   = w_fwd;
      end
   endgenerate

endmodule

// File: rtl/aes_sub_bytes_engine.sv
// Sequential SubBytes: serial 16-byte load, in-place substitution LANES bytes
// per cycle, then serial drain with backpressure.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_LOAD  | accept bytes into state[count]; byte 0 latches the mode
// ST_SUB   | substitute state[idx +: LANES] each cycle, 16/LANES cycles
// ST_DRAIN | present state[count] registered, advance on out_ready
module aes_sub_bytes_engine
   import aes_pkg::*;
#(
   parameter int LANES  = 1,
   parameter bit INV_EN = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   aes_sub_bytes_engine_if.slave        s_if,
   output logic                         busy
);

   localparam logic [3:0] IDX_LAST = 4'(AES_BLOCK_BYTES - LANES);

   generate
      if ((LANES < 1) || (LANES > AES_BLOCK_BYTES) || ((AES_BLOCK_BYTES % LANES) != 0)) begin : g_bad_lanes
         $error("aes_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   eng_state_e r_fsm;
   eng_state_e w_fsm_nxt;
   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_count;
   logic [3:0] w_count_nxt;
   logic [3:0] r_idx;
   logic [3:0] w_idx_nxt;
   logic       r_mode;
   logic       w_mode_nxt;
   logic       r_out_valid;
   byte_t      r_out_byte;

   logic [3:0] w_lane_idx [LANES];
   byte_t      w_sb_in    [LANES];
   byte_t      w_sb_out   [LANES];

   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         assign w_lane_idx[l] = r_idx + 4'(l);
         assign w_sb_in[l]    = r_state[w_lane_idx[l]];
         aes_sbox #(.INV_EN(INV_EN)) u_sbox (
            .i_in  (w_sb_in[l]),
            .i_inv (r_mode),
            .o_out (w_sb_out[l])
         );
      end
   endgenerate

   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_count_nxt = r_count;
      w_idx_nxt   = r_idx;
      w_mode_nxt  = r_mode;
      w_state_nxt = r_state;
      case (r_fsm)
         ST_LOAD: begin
            if (s_if.in_valid) begin
               w_state_nxt[r_count] = s_if.in_byte;
               if (r_count == 4'd0) w_mode_nxt = s_if.inv & INV_EN;
               if (r_count == 4'd15) begin
                  w_fsm_nxt   = ST_SUB;
                  w_count_nxt = 4'd0;
                  w_idx_nxt   = 4'd0;
               end else begin
                  w_count_nxt = r_count + 4'd1;
               end
            end
         end
         ST_SUB: begin
            for (int l = 0; l < LANES; l++) begin
               w_state_nxt[w_lane_idx[l]] = w_sb_out[l];
            end
            if (r_idx == IDX_LAST) begin
               w_fsm_nxt   = ST_DRAIN;
               w_count_nxt = 4'd0;
               w_idx_nxt   = 4'd0;
            end else begin
               w_idx_nxt = r_idx + 4'(LANES);
            end
         end
         ST_DRAIN: begin
            if (s_if.out_ready) begin
               if (r_count == 4'd15) begin
                  w_fsm_nxt   = ST_LOAD;
                  w_count_nxt = 4'd0;
               end else begin
                  w_count_nxt = r_count + 4'd1;
               end
            end
         end
         default: begin
            w_fsm_nxt   = ST_LOAD;
            w_count_nxt = 4'd0;
         end
      endcase
   end

   // Output byte is fetched from the post-update state so the first drain
   // byte already reflects the final substitution cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fsm       <= ST_LOAD;
         r_count     <= 4'd0;
         r_idx       <= 4'd0;
         r_mode      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_byte  <= 8'h00;
      end else begin
         r_fsm       <= w_fsm_nxt;
         r_count     <= w_count_nxt;
         r_idx       <= w_idx_nxt;
         r_mode      <= w_mode_nxt;
         r_out_valid <= (w_fsm_nxt == ST_DRAIN);
         r_out_byte  <= (w_fsm_nxt == ST_DRAIN) ? w_state_nxt[w_count_nxt] : 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      r_state <= w_state_nxt;
   end

   assign s_if.in_ready  = (r_fsm == ST_LOAD);
   assign s_if.out_valid = r_out_valid;
   assign s_if.out_byte  = r_out_byte;
   assign busy           = !((r_fsm == ST_LOAD) && (r_count == 4'd0));

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// Directed bench for the SubBytes engine: four instances (LANES 1/4/16 and a
// forward-only build) share one stimulus path selected by sel.
module tb_aes_sub_bytes_engine;
   import aes_pkg::*;

   localparam logic [15:0][7:0] SEQ = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [15:0][7:0] FWD = 128'h637c777bf26b6fc53001672bfed7ab76;

   typedef struct {
      int               sel;
      logic             inv0;
      logic             invr;
      logic [15:0][7:0] din;
      logic [15:0][7:0] dexp;
      int               lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int         sel = 0;
   logic       tb_in_valid = 1'b0;
   logic [7:0] tb_in_byte = 8'h00;
   logic       tb_inv = 1'b0;
   logic       tb_out_ready = 1'b0;

   logic       ov [4];
   logic       ir [4];
   logic       bz [4];
   logic [7:0] ob [4];

   generate
      for (genvar g = 0; g < 4; g++) begin : g_dut
         aes_sub_bytes_engine_if u_if ();
         assign u_if.in_valid  = tb_in_valid && (sel == g);
         assign u_if.in_byte   = tb_in_byte;
         assign u_if.inv       = tb_inv;
         assign u_if.out_ready = tb_out_ready && (sel == g);
         aes_sub_bytes_engine #(
            .LANES  ((g == 0 || g == 3) ? 1 : ((g == 1) ? 4 : 16)),
            .INV_EN (g != 3)
         ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .s_if  (u_if),
            .busy  (bz[g])
         );
         assign ov[g] = u_if.out_valid;
         assign ir[g] = u_if.in_ready;
         assign ob[g] = u_if.out_byte;
      end
   endgenerate

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", name, act, exp, sel, $time);
      end
   endtask

   task automatic send_block(input logic [15:0][7:0] din, input logic inv0, input logic invr,
                             input bit gaps);
      for (int i = 0; i < 16; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               tb_in_valid = 1'b0;
               tb_in_byte  = 8'($urandom);
               tb_inv      = 1'($urandom);
            end
         end
         @(negedge clk);
         tb_in_valid = 1'b1;
         tb_in_byte  = din[15-i];
         tb_inv      = (i == 0) ? inv0 : invr;
         chk($sformatf("in_ready_load[%0d]", i), ir[sel], 1);
         if (i == 1) chk("busy_load", bz[sel], 1);
         @(posedge clk);
      end
   endtask

   // Called right at the edge of the 16th transfer; that edge counts as 1.
   task automatic wait_lat(input int exp_lat);
      int lat;
      lat = 1;
      #1 tb_in_valid = 1'b0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (ov[sel]) break;
      end
      chk("latency", lat, exp_lat);
   endtask

   task automatic drain(input logic [15:0][7:0] dexp, input int nbytes, input bit bp);
      int i;
      int cyc;
      i   = 0;
      cyc = 0;
      while (i < nbytes && cyc < 300) begin
         @(negedge clk);
         tb_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         chk("out_valid_drain", ov[sel], 1);
         chk($sformatf("out_byte[%0d]", i), ob[sel], dexp[15-i]);
         chk("in_ready_drain", ir[sel], 0);
         chk("busy_drain", bz[sel], 1);
         @(posedge clk);
         if (tb_out_ready) i++;
         cyc++;
      end
      if (i < nbytes) chk("drain_timeout", i, nbytes);
   endtask

   task automatic check_idle();
      @(negedge clk);
      tb_out_ready = 1'b0;
      chk("idle_out_valid", ov[sel], 0);
      chk("idle_in_ready", ir[sel], 1);
      chk("idle_busy", bz[sel], 0);
      chk("idle_out_byte", ob[sel], 0);
   endtask

   vec_t vecs [11];

   initial begin
      vecs[0]  = '{0, 1'b0, 1'b0, SEQ, FWD, 17};
      vecs[1]  = '{0, 1'b1, 1'b1, FWD, SEQ, 17};
      vecs[2]  = '{1, 1'b0, 1'b0, SEQ, FWD, 5};
      vecs[3]  = '{1, 1'b1, 1'b1, FWD, SEQ, 5};
      vecs[4]  = '{2, 1'b0, 1'b0, SEQ, FWD, 2};
      vecs[5]  = '{2, 1'b1, 1'b1, FWD, SEQ, 2};
      vecs[6]  = '{0, 1'b0, 1'b1, SEQ, FWD, 17};
      vecs[7]  = '{0, 1'b1, 1'b0, FWD, SEQ, 17};
      vecs[8]  = '{3, 1'b1, 1'b1, SEQ, FWD, 17};
      vecs[9]  = '{2, 1'b0, 1'b0, {16{8'h53}}, {16{8'hed}}, 2};
      vecs[10] = '{1, 1'b1, 1'b1, {16{8'h63}}, {16{8'h00}}, 5};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         sel = k;
         chk("rst_out_valid", ov[k], 0);
         chk("rst_in_ready", ir[k], 1);
         chk("rst_busy", bz[k], 0);
         chk("rst_out_byte", ob[k], 0);
      end
      rst_n = 1'b1;

      for (int v = 0; v < 11; v++) begin
         sel = vecs[v].sel;
         send_block(vecs[v].din, vecs[v].inv0, vecs[v].invr, 1'b0);
         wait_lat(vecs[v].lat);
         drain(vecs[v].dexp, 16, 1'b0);
         check_idle();
      end

      // Input gaps plus output backpressure on the 4-lane build.
      sel = 1;
      send_block(SEQ, 1'b0, 1'b0, 1'b1);
      wait_lat(5);
      drain(FWD, 16, 1'b1);
      check_idle();

      // Reset after seven drained bytes, then a fresh all-zero block.
      sel = 0;
      send_block(SEQ, 1'b0, 1'b0, 1'b0);
      wait_lat(17);
      drain(FWD, 7, 1'b0);
      @(negedge clk);
      tb_out_ready = 1'b0;
      rst_n        = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", ov[0], 0);
      chk("midrst_in_ready", ir[0], 1);
      chk("midrst_busy", bz[0], 0);
      chk("midrst_out_byte", ob[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      send_block({16{8'h00}}, 1'b0, 1'b0, 1'b0);
      wait_lat(17);
      drain({16{8'h63}}, 16, 1'b0);
      check_idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
